peri_timer: RTL and testbench
=============================

PERI_TIMER -- requirements
Module: peri_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, giving CLOCK_50 cycles per timer tick (legal range 1..65535).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_bar  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port addr  input  2  peribus register select.
REQ-005 SHALL have port wdata  input  16  peribus write data.
REQ-006 SHALL have port we  input  1  peribus write strobe, one write per high cycle.
REQ-007 SHALL have port rdata  output  16  peribus read data for addr.
REQ-008 SHALL have port irq  output  1  level interrupt request to the core's interrupt controller.

Function
REQ-009 SHALL implement register map:
- 0 CTRL: [0] EN, [1] IE, [2] AUTO; bits [15:3] read 0.
- 1 PERIOD: 16-bit reload value.
- 2 COUNT: 16-bit current count, read-only; writes ignored.
- 3 STATUS: [0] FLAG; bits [15:1] read 0.
REQ-010 SHALL drive rdata combinationally from addr and current register state (zero-cycle read latency).
REQ-011 SHALL apply a write on the rising edge where we=1; the new value is visible on rdata in the following cycle.
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1 while EN=1, wrapping to 0; a tick occurs in the cycle the prescaler equals PRESCALE-1.
REQ-013 SHALL hold the prescaler at 0 while EN=0.
REQ-014 SHALL, on a tick with COUNT>0, decrement COUNT by 1.
REQ-015 SHALL, on a tick with COUNT=0, set FLAG; then if AUTO=1 load COUNT<=PERIOD, else clear EN (one-shot) and hold COUNT at 0.
REQ-016 SHALL, on a CTRL write that changes EN from 0 to 1, load COUNT<=PERIOD and clear the prescaler.
REQ-017 SHALL, on any PERIOD write, also load COUNT<=wdata and clear the prescaler.
REQ-018 SHALL clear FLAG on a STATUS write with wdata[0]=1; wdata[0]=0 has no effect.
REQ-019 SHALL drive irq = FLAG AND IE from registered state only (glitch-free, no added latency).
REQ-020 SHALL treat PERIOD=0 with AUTO=1 as setting FLAG on every tick.
REQ-021 SHALL, when a tick sets FLAG in the same cycle as a FLAG-clearing STATUS write, leave FLAG=1 (set wins).
REQ-022 SHALL, when a PERIOD write or EN 0->1 CTRL write coincides with a tick, apply the write and ignore the tick's COUNT/EN update; a FLAG set by that tick is still applied.
REQ-023 SHALL let a CTRL write with EN=0 stop counting immediately, COUNT retaining its value.
REQ-024 SHALL let a CTRL write with EN=1 in the same cycle as a one-shot expiry keep EN=1 (write wins).

Reset
REQ-025 SHALL, while reset_bar=0, force CTRL, PERIOD, COUNT, FLAG and the prescaler to 0, irq to 0, and rdata to 0 for every addr, independent of CLOCK_50.
REQ-026 SHALL resume normal operation on the first rising edge after reset_bar returns high, with the timer disabled.

Verification (PRESCALE=4)
REQ-027 One-shot: PERIOD=3, then CTRL=3'b011 -> COUNT 3,2,1,0 at ticks 4,8,12 cycles after CTRL write; FLAG=1 and irq=1 at cycle 16; EN reads 0; COUNT stays 0.
REQ-028 Auto-reload: PERIOD=1, CTRL=3'b111 -> COUNT alternates 1,0 every 4 cycles; FLAG set every 8 cycles; STATUS write 1 clears irq the following cycle.
REQ-029 Masked interrupt: one-shot with IE=0 -> FLAG=1, irq=0; then CTRL write IE=1 -> irq=1 the following cycle.
REQ-030 Collision: STATUS write wdata=1 in the expiry tick cycle -> FLAG and irq remain 1; second STATUS write clears both.
REQ-031 Reset mid-count: PERIOD=0x00FF, EN=1, reset_bar=0 after 10 cycles -> all reads 0x0000 and irq=0 immediately; after release, COUNT stays 0 with no ticks until EN is written.
REQ-032 Register map: write 0xFFFF to each addr -> CTRL reads 0x0007, PERIOD 0xFFFF, COUNT unchanged by its own write, STATUS 0x0000.

Source files
------------

// File: rtl/peri_timer_if.sv
// Peripheral bus bundle for peri_timer: register select, write data and
// strobe from the core, read data and interrupt request back to it.
interface peri_timer_if;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata,
        output irq
    );
endinterface

// File: rtl/peri_timer.sv
// Prescaled 16-bit down-counting timer with one-shot / auto-reload modes,
// a sticky expiry flag and a level interrupt, controlled over a 4-register
// peripheral bus:
//   0 CTRL   [0] EN, [1] IE, [2] AUTO
//   1 PERIOD reload value (writing it also reloads COUNT)
//   2 COUNT  current count, read-only
//   3 STATUS [0] FLAG, write 1 to clear
module peri_timer #(
    parameter int PRESCALE = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset_bar,
    peri_timer_if.slave bus
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        auto_q, auto_d;
    logic        flag_q, flag_d;
    logic [15:0] period_q, period_d;
    logic [15:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;

    logic wr_ctrl, wr_period, wr_status;
    logic tick, expire, en_rise, en_stop;

    assign wr_ctrl   = bus.we && (bus.addr == 2'd0);
    assign wr_period = bus.we && (bus.addr == 2'd1);
    assign wr_status = bus.we && (bus.addr == 2'd3);

    assign tick    = en_q && (presc_q == PS_LAST);
    assign expire  = tick && (count_q == 16'd0);
    assign en_rise = wr_ctrl && !en_q && bus.wdata[0];
    // A CTRL write clearing EN freezes COUNT in the same cycle, even on a tick.
    assign en_stop = wr_ctrl && !bus.wdata[0];

    // Next-state logic: bus writes take priority over the tick's COUNT/EN
    // update, while an expiry always sets FLAG.
    always_comb begin
        en_d     = en_q;
        ie_d     = ie_q;
        auto_d   = auto_q;
        period_d = period_q;
        count_d  = count_q;
        presc_d  = presc_q + 16'd1;
        flag_d   = flag_q;

        if (wr_ctrl) begin
            en_d   = bus.wdata[0];
            ie_d   = bus.wdata[1];
            auto_d = bus.wdata[2];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (wr_period) begin
            period_d = bus.wdata;
        end

        if (wr_period) begin
            count_d = bus.wdata;
        end else if (en_rise) begin
            count_d = period_q;
        end else if (en_stop) begin
            count_d = count_q;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = period_q;
            end
        end

        if (wr_period || en_rise || en_stop || !en_q || tick) begin
            presc_d = 16'd0;
        end

        if (expire) begin
            flag_d = 1'b1;
        end else if (wr_status && bus.wdata[0]) begin
            flag_d = 1'b0;
        end
    end

    // Register update; asynchronous reset leaves the timer disabled and idle.
    always_ff @(posedge CLOCK_50 or negedge reset_bar) begin
        if (!reset_bar) begin
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            auto_q   <= 1'b0;
            flag_q   <= 1'b0;
            period_q <= 16'd0;
            count_q  <= 16'd0;
            presc_q  <= 16'd0;
        end else begin
            en_q     <= en_d;
            ie_q     <= ie_d;
            auto_q   <= auto_d;
            flag_q   <= flag_d;
            period_q <= period_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
        end
    end

    // Zero-latency read mux straight off the registers.
    always_comb begin
        bus.rdata = 16'd0;
        case (bus.addr)
            2'd0: bus.rdata = {13'd0, auto_q, ie_q, en_q};
            2'd1: bus.rdata = period_q;
            2'd2: bus.rdata = count_q;
            2'd3: bus.rdata = {15'd0, flag_q};
            default: bus.rdata = 16'd0;
        endcase
    end

    assign bus.irq = flag_q & ie_q;

endmodule

// File: tb/tb_peri_timer.sv
// Bench for peri_timer with PRESCALE=4: directed scenarios with literal
// expectations, then randomized bus traffic, all shadowed by a behavioural
// model that a negedge process compares against on every cycle.
module tb_peri_timer;

    localparam int PRESCALE = 4;

    logic CLOCK_50  = 1'b0;
    logic reset_bar = 1'b0;

    peri_timer_if bus ();

    peri_timer #(.PRESCALE(PRESCALE)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_bar (reset_bar),
        .bus       (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: timer state plus the position inside the current
    // prescale period.
    int          m_phase;
    logic        m_en, m_ie, m_auto, m_flag;
    logic [15:0] m_period, m_count;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_en     = 1'b0;
        m_ie     = 1'b0;
        m_auto   = 1'b0;
        m_flag   = 1'b0;
        m_period = 16'd0;
        m_count  = 16'd0;
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {13'd0, m_auto, m_ie, m_en};
            2'd1:    return m_period;
            2'd2:    return m_count;
            default: return {15'd0, m_flag};
        endcase
    endfunction

    // One clock of time passes: first let the timer run, then let the bus
    // write overwrite whatever it touches.
    task automatic model_step();
        bit          tick, expire;
        int          n_phase;
        logic        n_en, n_ie, n_auto, n_flag;
        logic [15:0] n_period, n_count;

        tick   = m_en && (m_phase == PRESCALE - 1);
        expire = tick && (m_count == 16'd0);

        n_phase  = m_en ? (tick ? 0 : m_phase + 1) : 0;
        n_en     = m_en;
        n_ie     = m_ie;
        n_auto   = m_auto;
        n_flag   = m_flag;
        n_period = m_period;
        n_count  = m_count;

        if (tick) begin
            if (m_count > 0) begin
                n_count = m_count - 16'd1;
            end else begin
                n_flag = 1'b1;
                if (m_auto) n_count = m_period;
                else        n_en    = 1'b0;
            end
        end

        if (bus.we) begin
            case (bus.addr)
                2'd0: begin
                    if (!m_en && bus.wdata[0]) begin
                        n_count = m_period;
                        n_phase = 0;
                    end else if (!bus.wdata[0]) begin
                        n_count = m_count;
                        n_phase = 0;
                    end
                    n_en   = bus.wdata[0];
                    n_ie   = bus.wdata[1];
                    n_auto = bus.wdata[2];
                end
                2'd1: begin
                    n_period = bus.wdata;
                    n_count  = bus.wdata;
                    n_phase  = 0;
                end
                2'd3: begin
                    if (bus.wdata[0] && !expire) n_flag = 1'b0;
                end
                default: ;
            endcase
        end

        m_phase  = n_phase;
        m_en     = n_en;
        m_ie     = n_ie;
        m_auto   = n_auto;
        m_flag   = n_flag;
        m_period = n_period;
        m_count  = n_count;
    endtask

    // Continuous comparison of the visible outputs against the model.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("model_rdata", bus.rdata, model_read(bus.addr));
            chk("model_irq", {15'd0, bus.irq}, {15'd0, m_flag & m_ie});
        end
    end

    task automatic clk_cycle();
        @(posedge CLOCK_50);
        if (reset_bar) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_cycle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        clk_cycle();
        bus.we    = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string name);
        bus.addr = a;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 16'd0;
        reset_bar = 1'b0;
        model_reset();
        chk_en    = 1'b1;
        #2;
        rd_chk(2'd0, 16'h0000, "rst_ctrl");
        rd_chk(2'd1, 16'h0000, "rst_period");
        clk_cycle();
        rd_chk(2'd2, 16'h0000, "rst_count");
        rd_chk(2'd3, 16'h0000, "rst_status");
        chk("rst_irq", {15'd0, bus.irq}, 16'd0);
        reset_bar = 1'b1;
        idle(2);

        // One-shot with interrupt enabled
        wr(2'd1, 16'd3);
        wr(2'd0, 16'h0003);
        rd_chk(2'd2, 16'd3, "os_cnt3");
        idle(4);
        rd_chk(2'd2, 16'd2, "os_cnt2");
        idle(4);
        rd_chk(2'd2, 16'd1, "os_cnt1");
        idle(4);
        rd_chk(2'd2, 16'd0, "os_cnt0");
        rd_chk(2'd3, 16'd0, "os_flag_early");
        idle(4);
        rd_chk(2'd3, 16'd1, "os_flag");
        chk("os_irq", {15'd0, bus.irq}, 16'd1);
        rd_chk(2'd0, 16'h0002, "os_en_cleared");
        idle(8);
        rd_chk(2'd2, 16'd0, "os_cnt_hold");

        // Auto-reload with PERIOD=1
        wr(2'd3, 16'd1);
        chk("ar_irq_cleared", {15'd0, bus.irq}, 16'd0);
        wr(2'd1, 16'd1);
        wr(2'd0, 16'h0007);
        rd_chk(2'd2, 16'd1, "ar_cnt1");
        idle(4);
        rd_chk(2'd2, 16'd0, "ar_cnt0");
        rd_chk(2'd3, 16'd0, "ar_noflag");
        idle(4);
        rd_chk(2'd2, 16'd1, "ar_reload");
        rd_chk(2'd3, 16'd1, "ar_flag");
        chk("ar_irq", {15'd0, bus.irq}, 16'd1);
        wr(2'd3, 16'd1);
        chk("ar_irq_clr", {15'd0, bus.irq}, 16'd0);
        idle(7);
        rd_chk(2'd3, 16'd1, "ar_flag2");
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'd1);

        // Masked interrupt, then unmask
        wr(2'd1, 16'd1);
        wr(2'd0, 16'h0001);
        idle(8);
        rd_chk(2'd3, 16'd1, "mi_flag");
        chk("mi_irq_masked", {15'd0, bus.irq}, 16'd0);
        rd_chk(2'd0, 16'h0000, "mi_en_off");
        wr(2'd0, 16'h0002);
        chk("mi_irq_unmasked", {15'd0, bus.irq}, 16'd1);
        wr(2'd3, 16'd1);
        chk("mi_irq_clr", {15'd0, bus.irq}, 16'd0);

        // Flag clear colliding with expiry: set wins
        wr(2'd1, 16'd1);
        wr(2'd0, 16'h0003);
        idle(7);
        wr(2'd3, 16'd1);
        rd_chk(2'd3, 16'd1, "col_flag");
        chk("col_irq", {15'd0, bus.irq}, 16'd1);
        wr(2'd3, 16'd1);
        rd_chk(2'd3, 16'd0, "col_flag_clr");
        chk("col_irq_clr", {15'd0, bus.irq}, 16'd0);

        // EN=1 write in the one-shot expiry cycle keeps EN
        wr(2'd1, 16'd1);
        wr(2'd0, 16'h0001);
        idle(7);
        wr(2'd0, 16'h0001);
        rd_chk(2'd0, 16'h0001, "ow_en_kept");
        rd_chk(2'd3, 16'd1, "ow_flag");
        wr(2'd0, 16'h0000);
        wr(2'd3, 16'd1);

        // Register map with all-ones writes
        wr(2'd1, 16'd5);
        wr(2'd2, 16'hFFFF);
        rd_chk(2'd2, 16'd5, "map_count_ro");
        wr(2'd3, 16'hFFFF);
        rd_chk(2'd3, 16'h0000, "map_status");
        wr(2'd1, 16'hFFFF);
        rd_chk(2'd1, 16'hFFFF, "map_period");
        wr(2'd0, 16'hFFFF);
        rd_chk(2'd0, 16'h0007, "map_ctrl");
        rd_chk(2'd2, 16'hFFFF, "map_count_load");
        wr(2'd0, 16'h0000);

        // Reset in the middle of a count
        wr(2'd1, 16'h00FF);
        wr(2'd0, 16'h0003);
        idle(9);
        reset_bar = 1'b0;
        model_reset();
        rd_chk(2'd0, 16'h0000, "rr_ctrl");
        rd_chk(2'd1, 16'h0000, "rr_period");
        chk("rr_irq", {15'd0, bus.irq}, 16'd0);
        clk_cycle();
        rd_chk(2'd2, 16'h0000, "rr_count");
        rd_chk(2'd3, 16'h0000, "rr_status");
        clk_cycle();
        reset_bar = 1'b1;
        idle(10);
        rd_chk(2'd2, 16'h0000, "rr_count_idle");
        rd_chk(2'd0, 16'h0000, "rr_ctrl_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.addr = 2'($urandom_range(0, 3));
            bus.we   = ($urandom_range(0, 5) == 0);
            case (bus.addr)
                2'd0:    bus.wdata = 16'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h0000);
                2'd1:    bus.wdata = 16'($urandom_range(0, 6));
                default: bus.wdata = 16'($urandom_range(0, 65535));
            endcase
            if (i == 1500) begin
                bus.we    = 1'b0;
                reset_bar = 1'b0;
                model_reset();
                clk_cycle();
                reset_bar = 1'b1;
            end
            clk_cycle();
        end
        bus.we = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
